// File: rtl/tempsens_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the temperature-sensor calibration LUT: default sizes,
// loader FSM states and the power-on LUT contents the sensor also starts from.
package tempsens_pkg;

  localparam int DEF_N_VDAC = 6;
  localparam int DEF_N_LUT  = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    FINISH   = 2'd3
  } loader_state_e;

  // Entries past 31 read as zero so deeper LUT variants still get a defined image.
  function automatic logic [5:0] lutPreload(input int idx);
    logic [5:0] val;
    val = 6'd0;
    case (idx)
      12: val = 6'd47;
      13: val = 6'd45;
      14: val = 6'd42;
      15: val = 6'd38;
      16: val = 6'd34;
      17: val = 6'd30;
      18: val = 6'd27;
      19: val = 6'd23;
      20: val = 6'd19;
      21: val = 6'd15;
      22: val = 6'd10;
      23: val = 6'd5;
      default: val = (idx >= 0 && idx < 12) ? 6'd49 : 6'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cal_bit_timer.sv
`timescale 1ns/1ps
// Phase divider for the calibration serial clock: pulses phase_end_o on the
// last clk cycle of every CLK_DIV-cycle phase while enabled.
module cal_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  output logic phase_end_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;

  assign phase_end_o = en_i && (div_q == DW'(CLK_DIV - 1));

  // Restarting from zero when disabled keeps every phase exactly CLK_DIV long.
  always_comb begin
    div_d = div_q;
    if (!en_i || phase_end_o) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/cal_lut_loader.sv
`timescale 1ns/1ps
// Host-side loader for the sensor calibration LUT: keeps a local image, accepts
// entry writes while idle and shifts the whole image out MSB-first, entry 31 first.
module cal_lut_loader
  import tempsens_pkg::*;
#(
  parameter int N_VDAC  = DEF_N_VDAC,
  parameter int N_LUT   = DEF_N_LUT,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [N_VDAC-2:0] wr_addr,
  input  logic [N_LUT-1:0]  wr_data,
  input  logic              start,
  input  logic              cal_req,
  output logic              busy,
  output logic              done,
  output logic              cal_clk,
  output logic              cal_dat,
  output logic              cal_ena
);

  localparam int AW   = N_VDAC - 1;
  localparam int NENT = 1 << AW;
  localparam int NB   = NENT * N_LUT;
  localparam int BW   = $clog2(NB);
  localparam int PW   = (N_LUT > 1) ? $clog2(N_LUT) : 1;

  loader_state_e    state_q, state_d;
  logic [BW-1:0]    bitIdx_q, bitIdx_d;
  logic [AW-1:0]    entIdx_q, entIdx_d;
  logic [PW-1:0]    bitPos_q, bitPos_d;
  logic             loaded_q, loaded_d;
  logic             calEna_q;
  logic [N_LUT-1:0] lut_q [NENT];
  logic             wrFire;
  logic             timerEn;
  logic             phaseEnd;

  cal_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .en_i        (timerEn),
    .phase_end_o (phaseEnd)
  );

  assign wr_ready = (state_q == IDLE);
  assign wrFire   = wr_valid && wr_ready;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign cal_clk  = (state_q == SHIFT_HI);
  assign cal_dat  = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) ? lut_q[entIdx_q][bitPos_q] : 1'b0;
  assign cal_ena  = calEna_q;

  // Entry/bit-position counters walk the image so no divide-by-N_LUT is needed.
  always_comb begin
    state_d  = state_q;
    bitIdx_d = bitIdx_q;
    entIdx_d = entIdx_q;
    bitPos_d = bitPos_q;
    loaded_d = loaded_q;
    timerEn  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT_LO;
          bitIdx_d = '0;
          entIdx_d = AW'(NENT - 1);
          bitPos_d = PW'(N_LUT - 1);
          loaded_d = 1'b0;
        end
      end
      SHIFT_LO: begin
        timerEn = 1'b1;
        if (phaseEnd) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        timerEn = 1'b1;
        if (phaseEnd) begin
          if (bitIdx_q == BW'(NB - 1)) begin
            state_d = FINISH;
          end else begin
            state_d  = SHIFT_LO;
            bitIdx_d = bitIdx_q + 1'b1;
            if (bitPos_q == '0) begin
              bitPos_d = PW'(N_LUT - 1);
              entIdx_d = entIdx_q - 1'b1;
            end else begin
              bitPos_d = bitPos_q - 1'b1;
            end
          end
        end
      end
      FINISH: begin
        state_d  = IDLE;
        loaded_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bitIdx_q <= '0;
      entIdx_q <= '0;
      bitPos_q <= '0;
      loaded_q <= 1'b0;
      calEna_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitIdx_q <= bitIdx_d;
      entIdx_q <= entIdx_d;
      bitPos_q <= bitPos_d;
      loaded_q <= loaded_d;
      calEna_q <= cal_req && loaded_q && (state_q == IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NENT; i++) begin
        lut_q[i] <= N_LUT'(lutPreload(i));
      end
    end else if (wrFire) begin
      lut_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_cal_lut_loader.sv
`timescale 1ns/1ps
// Directed bench for cal_lut_loader: a 192-bit receiver clocked by cal_clk
// rebuilds the sensor image, compared against a hand-entered LUT table.
module tb_cal_lut_loader;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       wrValid  = 1'b0;
  logic [4:0] wrAddr   = '0;
  logic [5:0] wrData   = '0;
  logic       start    = 1'b0;
  logic       calReq   = 1'b0;
  logic       wrReady, busy, done, calClk, calDat, calEna;

  logic       start1   = 1'b0;
  logic       wrValid1 = 1'b0;
  logic [4:0] wrAddr1  = '0;
  logic [5:0] wrData1  = '0;
  logic       calReq1  = 1'b0;
  logic       wrReady1, busy1, done1, calClk1, calDat1, calEna1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int riseBase = 0;
  int rise0 = 0;
  int rise1 = 0;
  int viol0 = 0;
  int viol1 = 0;
  logic [191:0] rx0 = '0;
  logic [191:0] rx1 = '0;
  logic prevDat0 = 1'b0;
  logic prevDat1 = 1'b0;
  logic sawEna = 1'b0;
  logic [5:0] tab [32];

  always #5 clk = ~clk;

  cal_lut_loader #(.CLK_DIV(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_valid(wrValid), .wr_ready(wrReady),
    .wr_addr(wrAddr), .wr_data(wrData), .start(start), .cal_req(calReq),
    .busy(busy), .done(done), .cal_clk(calClk), .cal_dat(calDat), .cal_ena(calEna)
  );

  cal_lut_loader #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_valid(wrValid1), .wr_ready(wrReady1),
    .wr_addr(wrAddr1), .wr_data(wrData1), .start(start1), .cal_req(calReq1),
    .busy(busy1), .done(done1), .cal_clk(calClk1), .cal_dat(calDat1), .cal_ena(calEna1)
  );

  // Sensor-side shift registers: first bit sent ends up in the top position.
  always @(posedge calClk) begin
    rx0   <= {rx0[190:0], calDat};
    rise0 <= rise0 + 1;
  end

  always @(posedge calClk1) begin
    rx1   <= {rx1[190:0], calDat1};
    rise1 <= rise1 + 1;
  end

  // While cal_clk is high the data line must hold the value it had in the previous cycle.
  always @(negedge clk) begin
    if (calClk && (calDat !== prevDat0)) viol0 <= viol0 + 1;
    if (calClk1 && (calDat1 !== prevDat1)) viol1 <= viol1 + 1;
    prevDat0 <= calDat;
    prevDat1 <= calDat1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic loadPreloadTab();
    tab = '{6'd49, 6'd49, 6'd49, 6'd49, 6'd49, 6'd49, 6'd49, 6'd49,
            6'd49, 6'd49, 6'd49, 6'd49, 6'd47, 6'd45, 6'd42, 6'd38,
            6'd34, 6'd30, 6'd27, 6'd23, 6'd19, 6'd15, 6'd10, 6'd5,
            6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0};
  endtask

  // Receiver position 6e+b (0-based) holds entry e bit b.
  function automatic logic [191:0] imageOf();
    logic [191:0] img;
    img = '0;
    for (int e = 0; e < 32; e++) img[6*e +: 6] = tab[e];
    return img;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic writeEntry(input logic [4:0] a, input logic [5:0] d);
    wrValid = 1'b1;
    wrAddr  = a;
    wrData  = d;
    tick();
    wrValid = 1'b0;
  endtask

  task automatic applyStimulus(input bit sel, input bit withWrite, input logic [4:0] a, input logic [5:0] d);
    riseBase = sel ? rise1 : rise0;
    if (sel) start1 = 1'b1;
    else start = 1'b1;
    if (withWrite) begin
      wrValid = 1'b1;
      wrAddr  = a;
      wrData  = d;
    end
    cyc = 0;
    tick();
    start  = 1'b0;
    start1 = 1'b0;
    if (withWrite) wrValid = 1'b0;
  endtask

  task automatic waitDone(input bit sel, input int budget);
    sawEna = 1'b0;
    while (!(sel ? done1 : done) && cyc < budget) begin
      tick();
      if (cyc >= 2 && !(sel ? done1 : done) && (sel ? calEna1 : calEna)) sawEna = 1'b1;
    end
  endtask

  initial begin
    loadPreloadTab();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", 192'(busy), 192'(0));
    checkOutput("rstCalClk", 192'(calClk), 192'(0));
    checkOutput("rstCalDat", 192'(calDat), 192'(0));
    checkOutput("rstCalEna", 192'(calEna), 192'(0));
    checkOutput("rstDone", 192'(done), 192'(0));
    reset_n = 1'b1;
    tick();
    checkOutput("rstWrReady", 192'(wrReady), 192'(1));
    checkOutput("dut1WrReady", 192'(wrReady1), 192'(1));

    // Plain load of the power-on image.
    applyStimulus(1'b0, 1'b0, 5'd0, 6'd0);
    waitDone(1'b0, 2000);
    checkOutput("latencyDiv4", 192'(cyc), 192'(1537));
    checkOutput("risesDiv4", 192'(rise0 - riseBase), 192'(192));
    checkOutput("imagePreload", rx0, imageOf());
    tick();
    checkOutput("donePulseOneCycle", 192'(done), 192'(0));
    checkOutput("idleAfterLoad", 192'(busy), 192'(0));

    // One write on its own, a second write in the same cycle as start.
    writeEntry(5'd5, 6'd63);
    tab[5]  = 6'd63;
    tab[31] = 6'd1;
    applyStimulus(1'b0, 1'b1, 5'd31, 6'd1);
    waitDone(1'b0, 2000);
    checkOutput("imageWrites", rx0, imageOf());
    checkOutput("entry5Bits", 192'(rx0[35:30]), 192'(63));
    checkOutput("entry31Bits", 192'(rx0[191:186]), 192'(1));

    // Calibration enable around a load.
    tick();
    calReq = 1'b1;
    tick();
    tick();
    checkOutput("enaIdleLoaded", 192'(calEna), 192'(1));
    applyStimulus(1'b0, 1'b0, 5'd0, 6'd0);
    waitDone(1'b0, 2000);
    checkOutput("enaLowDuringLoad", 192'(sawEna), 192'(0));
    checkOutput("enaLowAtDone", 192'(calEna), 192'(0));
    tick();
    tick();
    checkOutput("enaAfterDone", 192'(calEna), 192'(1));

    // Write held during a load must stall and land once idle.
    applyStimulus(1'b0, 1'b0, 5'd0, 6'd0);
    tick();
    checkOutput("enaDropOnStart", 192'(calEna), 192'(0));
    repeat (9) tick();
    wrValid = 1'b1;
    wrAddr  = 5'd7;
    wrData  = 6'd21;
    tick();
    checkOutput("wrReadyBusy", 192'(wrReady), 192'(0));
    waitDone(1'b0, 2000);
    checkOutput("wrReadyAtFinish", 192'(wrReady), 192'(0));
    checkOutput("imageNoMidWrite", rx0, imageOf());
    tick();
    checkOutput("wrReadyIdle", 192'(wrReady), 192'(1));
    tick();
    wrValid = 1'b0;
    tab[7] = 6'd21;
    applyStimulus(1'b0, 1'b0, 5'd0, 6'd0);
    waitDone(1'b0, 2000);
    checkOutput("imageHeldWrite", rx0, imageOf());

    // Reset in the low phase of bit 100, then a clean reload.
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 6'd0);
    while (cyc < 803) tick();
    checkOutput("busyBeforeReset", 192'(busy), 192'(1));
    reset_n = 1'b0;
    #1;
    checkOutput("midRstCalClk", 192'(calClk), 192'(0));
    checkOutput("midRstBusy", 192'(busy), 192'(0));
    checkOutput("midRstCalEna", 192'(calEna), 192'(0));
    checkOutput("risesBeforeReset", 192'(rise0 - riseBase), 192'(100));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checkOutput("notLoadedAfterReset", 192'(calEna), 192'(0));
    loadPreloadTab();
    applyStimulus(1'b0, 1'b0, 5'd0, 6'd0);
    waitDone(1'b0, 2000);
    checkOutput("latencyRestart", 192'(cyc), 192'(1537));
    checkOutput("imageRestart", rx0, imageOf());
    tick();
    tick();
    checkOutput("enaAfterRestart", 192'(calEna), 192'(1));
    checkOutput("holdDiv4", 192'(viol0), 192'(0));

    // Fastest divider.
    applyStimulus(1'b1, 1'b0, 5'd0, 6'd0);
    waitDone(1'b1, 1000);
    checkOutput("latencyDiv1", 192'(cyc), 192'(385));
    checkOutput("risesDiv1", 192'(rise1 - riseBase), 192'(192));
    checkOutput("imageDiv1", rx1, imageOf());
    tick();
    checkOutput("idleDiv1", 192'(busy1), 192'(0));
    checkOutput("holdDiv1", 192'(viol1), 192'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
